layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/layer_sequencer.sv | 149 ++++++++++++++
 tb/tb_layer_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Sequences a chain of layer engines one at a time, skipping masked layers, and latches the last layer's result.
// Optional per-layer watchdog when LAYER_SEQ_WATCHDOG_EN is defined; start latency 1 cycle, done 1 cycle after FINISH.
module layer_sequencer #(
  parameter int NUM_LAYERS     = 3,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [NUM_LAYERS-1:0] skip_mask,
  input  logic                  abort,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  input  logic [DATA_W-1:0]     result_in,
  output logic [DATA_W-1:0]     value,
  output logic [2:0]            cur_layer,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {IDLE, START, WAIT, FINISH, FAIL} state_t;

  state_t                state;
  logic [NUM_LAYERS-1:0] mask_q;
  logic                  first_vld, next_vld, done_hit;
  logic [2:0]            first_idx, next_idx;
  logic [NUM_LAYERS-1:0] first_oh, next_oh;

  // Descending scans so the lowest qualifying index wins.
  always_comb begin
    first_vld = 1'b0;
    first_idx = 3'd0;
    next_vld  = 1'b0;
    next_idx  = 3'd0;
    done_hit  = 1'b0;
    first_oh  = '0;
    next_oh   = '0;
    for (int i = NUM_LAYERS-1; i >= 0; i--) begin
      if (!skip_mask[i]) begin
        first_vld = 1'b1;
        first_idx = 3'(i);
      end
      if (!mask_q[i] && (i > int'(cur_layer))) begin
        next_vld = 1'b1;
        next_idx = 3'(i);
      end
      if (3'(i) == cur_layer) done_hit = layer_done[i];
    end
    for (int i = 0; i < NUM_LAYERS; i++) begin
      first_oh[i] = (3'(i) == first_idx);
      next_oh[i]  = (3'(i) == next_idx);
    end
  end

`ifdef LAYER_SEQ_WATCHDOG_EN
  logic [15:0] wdog_cnt;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mask_q      <= '0;
      layer_start <= '0;
      value       <= '0;
      cur_layer   <= 3'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef LAYER_SEQ_WATCHDOG_EN
      error       <= 1'b0;
      wdog_cnt    <= 16'd0;
`endif
    end else begin
      layer_start <= '0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            mask_q <= skip_mask;
            busy   <= 1'b1;
`ifdef LAYER_SEQ_WATCHDOG_EN
            error  <= 1'b0;
`endif
            if (first_vld) begin
              cur_layer   <= first_idx;
              layer_start <= first_oh;
              state       <= START;
            end else begin
              state <= FINISH;
            end
          end
        end
        START: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= WAIT;
`ifdef LAYER_SEQ_WATCHDOG_EN
            wdog_cnt <= 16'd0;
`endif
          end
        end
        WAIT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (done_hit) begin
            if (next_vld) begin
              cur_layer   <= next_idx;
              layer_start <= next_oh;
              state       <= START;
            end else begin
              value <= result_in;
              state <= FINISH;
            end
          end else begin
`ifdef LAYER_SEQ_WATCHDOG_EN
            if (wdog_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
              error <= 1'b1;
              state <= FAIL;
            end else begin
              wdog_cnt <= wdog_cnt + 16'd1;
            end
`endif
          end
        end
        // done is raised on the way out so a late abort can still suppress it.
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= !abort;
        end
        FAIL: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: a cycle-stepped layer responder plus per-scenario inline checks.
module tb_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [2:0]  skip_mask;
  logic        abort;
  logic [2:0]  layer_start;
  logic [2:0]  layer_done;
  logic [31:0] result_in;
  logic [31:0] value;
  logic [2:0]  cur_layer;
  logic        busy;
  logic        done;
  logic        error;

  int tests = 0;
  int fails = 0;

  int         start_cnt, done_cnt, done_cyc, first_start_cyc, multi;
  logic [2:0] start_log [8];
  logic       busy_log [64];
  logic       err_log [64];

  layer_sequencer #(.NUM_LAYERS(3), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .skip_mask(skip_mask), .abort(abort),
    .layer_start(layer_start), .layer_done(layer_done), .result_in(result_in),
    .value(value), .cur_layer(cur_layer), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Runs ncyc cycles; cycle 0 optionally raises enable. Each started layer answers delay cycles later.
  task automatic serve(input bit en, input logic [2:0] mask, input int delay, input int abort_on,
                       input logic [2:0] stray, input int ncyc);
    int pend = -1;
    int pend_idx = 0;
    start_cnt = 0; done_cnt = 0; done_cyc = -1; first_start_cyc = -1; multi = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      busy_log[c] = busy;
      err_log[c]  = error;
      if (done) begin done_cnt++; done_cyc = c; end
      if ($countones(layer_start) > 1) multi++;
      enable     = en && (c == 0);
      skip_mask  = mask;
      layer_done = stray;
      abort      = 1'b0;
      if (pend == 0) begin
        layer_done[pend_idx] = 1'b1;
        if (pend_idx == abort_on) abort = 1'b1;
        pend = -1;
      end else if (pend > 0) begin
        pend--;
      end
      if (layer_start != 3'b000) begin
        if (start_cnt < 8) start_log[start_cnt] = layer_start;
        if (start_cnt == 0) first_start_cyc = c;
        start_cnt++;
        for (int i = 0; i < 3; i++) if (layer_start[i]) pend_idx = i;
        pend = delay - 1;
      end
    end
    enable = 1'b0; abort = 1'b0; layer_done = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; skip_mask = 3'b000; abort = 1'b0; layer_done = 3'b000; result_in = 32'h0;
    repeat (2) @(negedge clk);
    tests++; if (layer_start !== 3'b000) begin fails++; $display("FAIL reset_layer_start: got %b expected 000", layer_start); end
    tests++; if (value !== 32'h0) begin fails++; $display("FAIL reset_value: got %h expected 0", value); end
    tests++; if (cur_layer !== 3'd0) begin fails++; $display("FAIL reset_cur_layer: got %0d expected 0", cur_layer); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b expected 0", error); end
    rst = 1'b0;
  endtask

  task automatic test_full_pass();
    result_in = 32'h0000_002A;
    serve(1'b1, 3'b000, 4, -1, 3'b000, 22);
    tests++; if (start_cnt !== 3) begin fails++; $display("FAIL full_start_cnt: got %0d expected 3", start_cnt); end
    tests++; if ({start_log[0], start_log[1], start_log[2]} !== 9'b001_010_100) begin fails++;
      $display("FAIL full_order: got %b %b %b expected 001 010 100", start_log[0], start_log[1], start_log[2]); end
    tests++; if (first_start_cyc !== 1) begin fails++; $display("FAIL full_start_latency: got %0d expected 1", first_start_cyc); end
    tests++; if (busy_log[1] !== 1'b1) begin fails++; $display("FAIL full_busy: got %b expected 1", busy_log[1]); end
    tests++; if (done_cnt !== 1 || done_cyc !== 17) begin fails++;
      $display("FAIL full_done: got count %0d at cycle %0d expected 1 at 17", done_cnt, done_cyc); end
    tests++; if (value !== 32'h2A) begin fails++; $display("FAIL full_value: got %h expected 2a", value); end
    tests++; if (multi !== 0) begin fails++; $display("FAIL full_onehot: got %0d multi-hot cycles expected 0", multi); end
  endtask

  task automatic test_skip_middle();
    result_in = 32'h0000_0055;
    serve(1'b1, 3'b010, 4, -1, 3'b000, 16);
    tests++; if (start_cnt !== 2 || start_log[0] !== 3'b001 || start_log[1] !== 3'b100) begin fails++;
      $display("FAIL skip_order: got %0d starts %b %b expected 2 starts 001 100", start_cnt, start_log[0], start_log[1]); end
    tests++; if (done_cnt !== 1 || done_cyc !== 12) begin fails++;
      $display("FAIL skip_done: got count %0d at cycle %0d expected 1 at 12", done_cnt, done_cyc); end
    tests++; if (value !== 32'h55) begin fails++; $display("FAIL skip_value: got %h expected 55", value); end
  endtask

  task automatic test_all_skip();
    result_in = 32'h0000_0077;
    serve(1'b1, 3'b111, 4, -1, 3'b000, 6);
    tests++; if (done_cnt !== 1 || done_cyc !== 2) begin fails++;
      $display("FAIL allskip_done: got count %0d at cycle %0d expected 1 at 2", done_cnt, done_cyc); end
    tests++; if (start_cnt !== 0) begin fails++; $display("FAIL allskip_starts: got %0d expected 0", start_cnt); end
    tests++; if (value !== 32'h55) begin fails++; $display("FAIL allskip_value: got %h expected 55", value); end
  endtask

  task automatic test_abort();
    result_in = 32'h0000_0099;
    serve(1'b1, 3'b000, 4, 1, 3'b000, 18);
    tests++; if (start_cnt !== 2) begin fails++; $display("FAIL abort_starts: got %0d expected 2", start_cnt); end
    tests++; if (busy_log[11] !== 1'b0) begin fails++; $display("FAIL abort_idle: got busy %b expected 0", busy_log[11]); end
    tests++; if (done_cnt !== 0) begin fails++; $display("FAIL abort_done: got %0d expected 0", done_cnt); end
    tests++; if (value !== 32'h55) begin fails++; $display("FAIL abort_value: got %h expected 55", value); end
    tests++; if (cur_layer !== 3'd1) begin fails++; $display("FAIL abort_cur_hold: got %0d expected 1", cur_layer); end
  endtask

  task automatic test_stray_done();
    result_in = 32'h0000_003C;
    serve(1'b1, 3'b100, 4, -1, 3'b100, 16);
    tests++; if (done_cnt !== 1 || done_cyc !== 12) begin fails++;
      $display("FAIL stray_done: got count %0d at cycle %0d expected 1 at 12", done_cnt, done_cyc); end
    tests++; if (start_cnt !== 2 || value !== 32'h3C) begin fails++;
      $display("FAIL stray_result: got %0d starts value %h expected 2 starts value 3c", start_cnt, value); end
  endtask

  task automatic test_watchdog();
`ifdef LAYER_SEQ_WATCHDOG_EN
    serve(1'b1, 3'b000, 1000, -1, 3'b000, 14);
    tests++; if (err_log[9] !== 1'b0 || err_log[10] !== 1'b1) begin fails++;
      $display("FAIL wdog_timing: got error %b,%b at cycles 9,10 expected 0,1", err_log[9], err_log[10]); end
    tests++; if (busy_log[11] !== 1'b0) begin fails++; $display("FAIL wdog_idle: got busy %b expected 0", busy_log[11]); end
    tests++; if (done_cnt !== 0) begin fails++; $display("FAIL wdog_done: got %0d expected 0", done_cnt); end
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL wdog_sticky: got %b expected 1", error); end
    serve(1'b1, 3'b111, 4, -1, 3'b000, 4);
    tests++; if (err_log[1] !== 1'b0) begin fails++; $display("FAIL wdog_clear: got %b expected 0", err_log[1]); end
`else
    serve(1'b1, 3'b000, 1000, -1, 3'b000, 30);
    tests++; if (error !== 1'b0 || busy !== 1'b1) begin fails++;
      $display("FAIL nowdog_wait: got error %b busy %b expected 0 1", error, busy); end
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL nowdog_abort: got busy %b expected 0", busy); end
`endif
  endtask

  task automatic test_reset_mid_pass();
    int busy_seen;
    result_in = 32'h0000_00EE;
    serve(1'b1, 3'b000, 4, -1, 3'b000, 8);
    @(negedge clk); rst = 1'b1; abort = 1'b1; enable = 1'b1;
    @(negedge clk); rst = 1'b0; abort = 1'b0; enable = 1'b0;
    tests++; if (layer_start !== 3'b000 || busy !== 1'b0 || done !== 1'b0) begin fails++;
      $display("FAIL rstmid_ctrl: got start %b busy %b done %b expected 000 0 0", layer_start, busy, done); end
    tests++; if (value !== 32'h0) begin fails++; $display("FAIL rstmid_value: got %h expected 0", value); end
    tests++; if (cur_layer !== 3'd0 || error !== 1'b0) begin fails++;
      $display("FAIL rstmid_cur_err: got cur %0d error %b expected 0 0", cur_layer, error); end
    serve(1'b0, 3'b000, 4, -1, 3'b010, 10);
    busy_seen = 0;
    for (int c = 0; c < 10; c++) if (busy_log[c]) busy_seen++;
    tests++; if (start_cnt !== 0 || done_cnt !== 0 || busy_seen !== 0) begin fails++;
      $display("FAIL rstmid_stray: got starts %0d dones %0d busy cycles %0d expected 0 0 0", start_cnt, done_cnt, busy_seen); end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_skip_middle();
    test_all_skip();
    test_abort();
    test_stray_done();
    test_watchdog();
    test_reset_mid_pass();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
